// File: rtl/xexch_arb_engine.sv
// xexch_arb_engine: cross-exchange arbitrage engine.
//   Holds best bid/ask (price, qty) per venue with per-venue staleness aging.
//   Any accepted table change marks the book dirty; from IDLE a scan walks all
//   ordered (buy b, sell s) pairs, one per cycle. It keeps the widest qualifying
//   spread, divides it into bps with a restoring divider and presents the
//   result on a valid/ready port.
// Ports:
//   clk, rst             clock, async active-high reset
//   upd_*                table update request (valid/ready), clear, side, price, qty
//   cfg_min_bps          minimum profit threshold in bps
//   opp_*                opportunity output (valid/ready) with pair, prices, qty, bps
//   stale_mask           per-exchange stale flags
//   stat_*               accepted updates, completed scans, opportunity handshakes

// One venue's top-of-book plus its age counter.
module xexch_book_entry #(
  parameter int PRICE_WIDTH  = 64,
  parameter int QTY_WIDTH    = 64,
  parameter int AGE_WIDTH    = 20,
  parameter int STALE_CYCLES = 300000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic                   wr_side,
  input  logic                   wr_clear,
  input  logic [PRICE_WIDTH-1:0] wr_price,
  input  logic [QTY_WIDTH-1:0]   wr_qty,
  output logic [PRICE_WIDTH-1:0] bid_px,
  output logic [QTY_WIDTH-1:0]   bid_qty,
  output logic [PRICE_WIDTH-1:0] ask_px,
  output logic [QTY_WIDTH-1:0]   ask_qty,
  output logic                   stale
);
  localparam logic [AGE_WIDTH-1:0] STALE_AGE = AGE_WIDTH'(STALE_CYCLES);

  logic [AGE_WIDTH-1:0] age;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bid_px  <= '0;
      bid_qty <= '0;
      ask_px  <= '0;
      ask_qty <= '0;
      age     <= '0;
    end else if (wr) begin
      age <= '0;
      if (wr_clear) begin
        bid_px  <= '0;
        bid_qty <= '0;
        ask_px  <= '0;
        ask_qty <= '0;
      end else if (wr_side) begin
        ask_px  <= wr_price;
        ask_qty <= wr_qty;
      end else begin
        bid_px  <= wr_price;
        bid_qty <= wr_qty;
      end
    end else if (age != STALE_AGE) begin
      age <= age + AGE_WIDTH'(1);
    end
  end

  assign stale = (age == STALE_AGE);
endmodule

module xexch_arb_engine #(
  parameter int PRICE_WIDTH  = 64,
  parameter int QTY_WIDTH    = 64,
  parameter int NUM_EXCH     = 4,
  parameter int EXCH_W       = 2,
  parameter int BPS_WIDTH    = 16,
  parameter int AGE_WIDTH    = 20,
  parameter int STALE_CYCLES = 300000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [EXCH_W-1:0]      upd_exch,
  input  logic                   upd_side,
  input  logic                   upd_clear,
  input  logic [PRICE_WIDTH-1:0] upd_price,
  input  logic [QTY_WIDTH-1:0]   upd_qty,
  input  logic [BPS_WIDTH-1:0]   cfg_min_bps,
  output logic                   opp_valid,
  input  logic                   opp_ready,
  output logic [EXCH_W-1:0]      opp_buy_exch,
  output logic [EXCH_W-1:0]      opp_sell_exch,
  output logic [PRICE_WIDTH-1:0] opp_buy_price,
  output logic [PRICE_WIDTH-1:0] opp_sell_price,
  output logic [QTY_WIDTH-1:0]   opp_qty,
  output logic [BPS_WIDTH-1:0]   opp_profit_bps,
  output logic [NUM_EXCH-1:0]    stale_mask,
  output logic [63:0]            stat_updates,
  output logic [63:0]            stat_scans,
  output logic [63:0]            stat_opps
);
  // Wide enough for diff*10000, min_bps*ask and ask<<BPS_WIDTH without truncation.
  localparam int PROD_W = PRICE_WIDTH + BPS_WIDTH + 14;
  localparam int CNT_W  = $clog2(BPS_WIDTH + 1);
  localparam logic [EXCH_W-1:0] LAST = EXCH_W'(NUM_EXCH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DIV, EMIT} state_t;
  state_t state, state_nxt;

  logic [NUM_EXCH-1:0][PRICE_WIDTH-1:0] bid_px, ask_px;
  logic [NUM_EXCH-1:0][QTY_WIDTH-1:0]   bid_qty, ask_qty;

  logic upd_fire;
  assign upd_fire = upd_valid & upd_ready;

  for (genvar e = 0; e < NUM_EXCH; e++) begin : g_book
    xexch_book_entry #(
      .PRICE_WIDTH(PRICE_WIDTH), .QTY_WIDTH(QTY_WIDTH),
      .AGE_WIDTH(AGE_WIDTH), .STALE_CYCLES(STALE_CYCLES)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .wr       (upd_fire && (upd_exch == EXCH_W'(e))),
      .wr_side  (upd_side),
      .wr_clear (upd_clear),
      .wr_price (upd_price),
      .wr_qty   (upd_qty),
      .bid_px   (bid_px[e]),
      .bid_qty  (bid_qty[e]),
      .ask_px   (ask_px[e]),
      .ask_qty  (ask_qty[e]),
      .stale    (stale_mask[e])
    );
  end

  logic                   dirty;
  logic [EXCH_W-1:0]      b_idx, s_idx;
  logic                   cand_v;
  logic [EXCH_W-1:0]      cand_b, cand_s;
  logic [PRICE_WIDTH-1:0] cand_ask, cand_bid, cand_diff;
  logic [QTY_WIDTH-1:0]   cand_qty;
  logic [CNT_W-1:0]       div_cnt;
  logic                   sat;
  logic [PROD_W-1:0]      rem, dsr;
  logic [BPS_WIDTH-2:0]   quo;

  // Current pair evaluation.
  logic [PRICE_WIDTH-1:0] cur_ask, cur_bid, cur_diff;
  logic [QTY_WIDTH-1:0]   cur_qty;
  logic [PROD_W-1:0]      lhs, rhs;
  logic                   qual, better, last_pair;

  assign cur_ask   = ask_px[b_idx];
  assign cur_bid   = bid_px[s_idx];
  assign cur_diff  = cur_bid - cur_ask;
  assign cur_qty   = (ask_qty[b_idx] < bid_qty[s_idx]) ? ask_qty[b_idx] : bid_qty[s_idx];
  assign lhs       = PROD_W'(cur_diff) * PROD_W'(10000);
  assign rhs       = PROD_W'(cfg_min_bps) * PROD_W'(cur_ask);
  assign qual      = (b_idx != s_idx) && (cur_ask != '0) && (cur_bid != '0) &&
                     !stale_mask[b_idx] && !stale_mask[s_idx] &&
                     (cur_bid > cur_ask) && (lhs >= rhs);
  // Strictly greater only, so the earliest pair wins a tie.
  assign better    = !cand_v || (cur_diff > cand_diff);
  assign last_pair = (b_idx == LAST) && (s_idx == LAST);

  // Divider step: one quotient bit per cycle, MSB first.
  logic [PROD_W-1:0]    div_num;
  logic                 ge;
  logic [BPS_WIDTH-1:0] quo_nxt;
  assign div_num = PROD_W'(cand_diff) * PROD_W'(10000);
  assign ge      = (rem >= dsr);
  assign quo_nxt = {quo, ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (dirty) state_nxt = SCAN;
      SCAN: if (last_pair) state_nxt = (cand_v || qual) ? DIV : IDLE;
      DIV:  if (div_cnt == CNT_W'(BPS_WIDTH)) state_nxt = EMIT;
      EMIT: if (opp_valid && opp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_ready      <= 1'b0;
      dirty          <= 1'b0;
      b_idx          <= '0;
      s_idx          <= '0;
      cand_v         <= 1'b0;
      cand_b         <= '0;
      cand_s         <= '0;
      cand_ask       <= '0;
      cand_bid       <= '0;
      cand_diff      <= '0;
      cand_qty       <= '0;
      div_cnt        <= '0;
      sat            <= 1'b0;
      rem            <= '0;
      dsr            <= '0;
      quo            <= '0;
      opp_valid      <= 1'b0;
      opp_buy_exch   <= '0;
      opp_sell_exch  <= '0;
      opp_buy_price  <= '0;
      opp_sell_price <= '0;
      opp_qty        <= '0;
      opp_profit_bps <= '0;
      stat_updates   <= '0;
      stat_scans     <= '0;
      stat_opps      <= '0;
    end else begin
      upd_ready <= (state_nxt != SCAN);
      if (upd_fire) stat_updates <= stat_updates + 64'd1;

      // An update landing on the IDLE->SCAN edge is already in the table the
      // scan reads, so the clear takes priority.
      if (state == IDLE && dirty) dirty <= 1'b0;
      else if (upd_fire)          dirty <= 1'b1;

      case (state)
        IDLE: if (dirty) begin
          b_idx  <= '0;
          s_idx  <= '0;
          cand_v <= 1'b0;
        end
        SCAN: begin
          if (qual && better) begin
            cand_v    <= 1'b1;
            cand_b    <= b_idx;
            cand_s    <= s_idx;
            cand_ask  <= cur_ask;
            cand_bid  <= cur_bid;
            cand_diff <= cur_diff;
            cand_qty  <= cur_qty;
          end
          if (s_idx == LAST) begin
            s_idx <= '0;
            b_idx <= b_idx + EXCH_W'(1);
          end else begin
            s_idx <= s_idx + EXCH_W'(1);
          end
          if (last_pair) begin
            stat_scans <= stat_scans + 64'd1;
            div_cnt    <= '0;
          end
        end
        DIV: begin
          div_cnt <= div_cnt + CNT_W'(1);
          if (div_cnt == '0) begin
            // Quotient would not fit in BPS_WIDTH bits: saturate.
            sat <= (div_num >= (PROD_W'(cand_ask) << BPS_WIDTH));
            rem <= div_num;
            dsr <= PROD_W'(cand_ask) << (BPS_WIDTH - 1);
            quo <= '0;
          end else begin
            if (!sat) begin
              if (ge) rem <= rem - dsr;
              quo <= quo_nxt[BPS_WIDTH-2:0];
            end
            dsr <= dsr >> 1;
          end
          if (div_cnt == CNT_W'(BPS_WIDTH)) begin
            opp_valid      <= 1'b1;
            opp_buy_exch   <= cand_b;
            opp_sell_exch  <= cand_s;
            opp_buy_price  <= cand_ask;
            opp_sell_price <= cand_bid;
            opp_qty        <= cand_qty;
            opp_profit_bps <= sat ? '1 : quo_nxt;
          end
        end
        EMIT: if (opp_valid && opp_ready) begin
          opp_valid <= 1'b0;
          stat_opps <= stat_opps + 64'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/xexch_arb_engine.md
Name: xexch_arb_engine

Overview:
Parametrised cross-exchange arbitrage engine for NUM_EXCH venues. It holds a top-of-book table (best bid and best ask, each with price and quantity) per exchange and tracks staleness per exchange. After every table change it runs a sequential scan over all ordered (buy, sell) exchange pairs and computes the exact profit in bps with a multi-cycle restoring divider. The winning opportunity is emitted on a valid/ready output. It sits between the per-exchange order-book processors and the order-execution logic.

Parameters:
PRICE_WIDTH, 64, fixed-point price width
QTY_WIDTH, 64, quantity width
NUM_EXCH, 4, number of exchanges (2..16)
EXCH_W, 2, exchange index width, clog2(NUM_EXCH)
BPS_WIDTH, 16, profit/threshold width in bps
AGE_WIDTH, 20, staleness counter width
STALE_CYCLES, 300000, age at which an exchange becomes stale (1 ms at 300 MHz)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
upd_valid  in  1  table update request
upd_ready  out  1  update accepted when upd_valid and upd_ready are both 1
upd_exch  in  EXCH_W  target exchange
upd_side  in  1  0 = bid, 1 = ask
upd_clear  in  1  invalidate both sides of upd_exch (price and qty ignored)
upd_price  in  PRICE_WIDTH  new best price; 0 invalidates that side
upd_qty  in  QTY_WIDTH  new best quantity
cfg_min_bps  in  BPS_WIDTH  minimum profit threshold, quasi-static
opp_valid  out  1  opportunity available
opp_ready  in  1  consumer accept
opp_buy_exch  out  EXCH_W  exchange whose ask is lifted
opp_sell_exch  out  EXCH_W  exchange whose bid is hit
opp_buy_price  out  PRICE_WIDTH  ask price
opp_sell_price  out  PRICE_WIDTH  bid price
opp_qty  out  QTY_WIDTH  min(ask qty, bid qty)
opp_profit_bps  out  BPS_WIDTH  floor((bid-ask)*10000/ask), saturated
stale_mask  out  NUM_EXCH  bit i = 1 while exchange i is stale
stat_updates  out  64  accepted updates
stat_scans  out  64  completed scans
stat_opps  out  64  opp handshakes

Behaviour:
- Reset: asynchronous and immediate, including mid-scan and mid-divide. All table entries are invalid with price and qty 0. All ages are 0, stale_mask = 0, all outputs and counters are 0, state = IDLE, dirty = 0. The upd_ready reset value is 0; it becomes 1 on the first clk after rst deasserts.
- Table write: takes effect at the edge of acceptance. Side valid = (price != 0). Writing either side of exchange e, or clearing e, resets age[e] to 0. Otherwise age[e] increments each cycle, saturating at STALE_CYCLES. stale_mask[e] = (age[e] == STALE_CYCLES).
- dirty flag: set by any accepted update. Cleared on the IDLE->SCAN edge; this clear wins over an update accepted on the same edge, because that update is already visible to the scan.
- upd_ready: 0 in SCAN, 1 in every other state.
- FSM states:
  - IDLE: go to SCAN if dirty.
  - SCAN: exactly NUM_EXCH^2 cycles, one pair per cycle with buy b (outer loop) and sell s (inner loop), both counting 0..NUM_EXCH-1.
    - A pair qualifies if all of the following hold: b != s; ask[b] is valid; bid[s] is valid; neither b nor s is stale; bid[s] > ask[b]; and (bid[s]-ask[b])*10000 >= cfg_min_bps*ask[b], evaluated at full product widths with no truncation.
    - The kept candidate is the qualifying pair with the largest (bid-ask). On equal spread, the earlier pair is kept (replace only on strictly greater).
    - On the final pair: stat_scans increments; go to DIV if a candidate exists, else IDLE.
  - DIV: BPS_WIDTH+1 cycles.
    - Cycle 0: if diff*10000 >= ask<<BPS_WIDTH, the result saturates to all-ones.
    - Otherwise: BPS_WIDTH restoring shift-subtract steps, MSB first.
    - Then go to EMIT.
  - EMIT: opp_* fields are loaded and opp_valid = 1. Fields stay stable until the opp_valid & opp_ready handshake. On handshake: opp_valid drops the next cycle, stat_opps increments, go to IDLE. Updates arriving during DIV or EMIT set dirty, so a rescan follows the handshake.
- Latency: last update accepted at edge E, FSM in IDLE -> SCAN from E+1 -> opp_valid rises at edge E+NUM_EXCH^2+BPS_WIDTH+2.
- The same-exchange crossed book (b == s) is never reported.

Test Plan:
- NUM_EXCH=3, BPS_WIDTH=16, min=10. Ask0=100000, bid1=100200, update at edge E -> opp_valid at E+27 with buy=0, sell=1, profit_bps=20, qty=min of the two quantities; stat_scans=1.
- Same setup but bid1=100050 (5 bps) -> scan completes, opp_valid stays 0, FSM returns to IDLE, stat_opps=0.
- STALE_CYCLES=100: set ask0/bid1 as in the first test, hold opp_ready=1, then wait 100 cycles -> stale_mask[1]=1. Rewrite ask0 -> scan reports no opp. Rewrite bid1=100200 -> opp reported at 20 bps.
- Pair selection: bid1=100200, bid2=100300, ask0=100000, exch0 bid=200000 with ask0 (self-crossed) -> buy=0, sell=2, profit 30. The self-crossed exchange 0 is ignored.
- Saturation: ask0=1, bid1=100 -> profit_bps=65535.
- Backpressure/reset: hold opp_ready=0 for 50 cycles -> fields stable and upd_ready=1. An update accepted during EMIT causes a rescan after the handshake. Asserting rst mid-DIV -> opp_valid=0 and all counters 0 immediately, without waiting for clk.
